// File: rtl/wb_bus_arbiter_if.sv
// Bus bundle for wb_bus_arbiter: two Wishbone master ports, one slave port
// and the current grant.
//   master modport : the side that drives the arbiter's inputs (masters + slave)
//   slave  modport : the arbiter's own view (i_* in, o_* out)
// Signals keep the i_/o_ names as seen from the arbiter.
interface wb_bus_arbiter_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic [AW-1:0] i_m0_addr;
    logic          i_m0_cyc;
    logic [SW-1:0] i_m0_stb;
    logic          i_m0_we;
    logic [DW-1:0] i_m0_dat;
    logic [DW-1:0] o_m0_dat;
    logic          o_m0_ack;
    logic          o_m0_err;

    logic [AW-1:0] i_m1_addr;
    logic          i_m1_cyc;
    logic [SW-1:0] i_m1_stb;
    logic          i_m1_we;
    logic [DW-1:0] i_m1_dat;
    logic [DW-1:0] o_m1_dat;
    logic          o_m1_ack;
    logic          o_m1_err;

    logic [AW-1:0] o_s_addr;
    logic          o_s_cyc;
    logic [SW-1:0] o_s_stb;
    logic          o_s_we;
    logic [DW-1:0] o_s_dat;
    logic [DW-1:0] i_s_dat;
    logic          i_s_ack;
    logic          i_s_err;

    logic [1:0]    o_grant;

    modport master (
        output i_m0_addr, i_m0_cyc, i_m0_stb, i_m0_we, i_m0_dat,
        output i_m1_addr, i_m1_cyc, i_m1_stb, i_m1_we, i_m1_dat,
        output i_s_dat, i_s_ack, i_s_err,
        input  o_m0_dat, o_m0_ack, o_m0_err,
        input  o_m1_dat, o_m1_ack, o_m1_err,
        input  o_s_addr, o_s_cyc, o_s_stb, o_s_we, o_s_dat,
        input  o_grant
    );

    modport slave (
        input  i_m0_addr, i_m0_cyc, i_m0_stb, i_m0_we, i_m0_dat,
        input  i_m1_addr, i_m1_cyc, i_m1_stb, i_m1_we, i_m1_dat,
        input  i_s_dat, i_s_ack, i_s_err,
        output o_m0_dat, o_m0_ack, o_m0_err,
        output o_m1_dat, o_m1_ack, o_m1_err,
        output o_s_addr, o_s_cyc, o_s_stb, o_s_we, o_s_dat,
        output o_grant
    );
endinterface

// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter with round-robin fairness.
// Master 0 is the instruction fetcher, master 1 the load/store unit.
// Whole cyc-framed cycles are granted; outputs are combinational from state.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus            : wb_bus_arbiter_if.slave (master ports, slave port, o_grant)
// Optional watchdog: define WB_ARB_TIMEOUT_EN to abort a cycle with err after
// TIMEOUT waiting cycles without ack/err.
module wb_bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    wb_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;     // last served master: 0 = m0, 1 = m1

    logic       grant0_c, grant1_c;
    logic       owner_cyc_c;
    logic [3:0] owner_stb_c;
    logic       abort_c;

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("wb_bus_arbiter: TIMEOUT must be at least 1");
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Next-state: round-robin in IDLE, rearbitrate in the release cycle
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (bus.i_m0_cyc && bus.i_m1_cyc) state_d = last_q ? GRANT0 : GRANT1;
                else if (bus.i_m0_cyc)             state_d = GRANT0;
                else if (bus.i_m1_cyc)             state_d = GRANT1;
            end
            GRANT0: begin
                if (!bus.i_m0_cyc) begin
                    last_d  = 1'b0;
                    state_d = bus.i_m1_cyc ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (!bus.i_m1_cyc) begin
                    last_d  = 1'b1;
                    state_d = bus.i_m0_cyc ? GRANT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant0_c    = (state_q == GRANT0);
    assign grant1_c    = (state_q == GRANT1);
    assign owner_cyc_c = (grant0_c & bus.i_m0_cyc) | (grant1_c & bus.i_m1_cyc);
    assign owner_stb_c = grant1_c ? bus.i_m1_stb : bus.i_m0_stb;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign abort_c = (grant0_c | grant1_c) && (cnt_q == CNT_W'(TIMEOUT));

    // Count cycles the owner is strobing without response; idle/release clears
    always_comb begin
        cnt_d = cnt_q;
        if (!owner_cyc_c || bus.i_s_ack || bus.i_s_err || abort_c) cnt_d = '0;
        else if (owner_stb_c != 4'b0000)                           cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    assign abort_c = 1'b0;
`endif

    // Slave-side mux; address/we/data follow m0 unless m1 owns the bus
    always_comb begin
        bus.o_s_addr = bus.i_m0_addr;
        bus.o_s_we   = bus.i_m0_we;
        bus.o_s_dat  = bus.i_m0_dat;
        if (grant1_c) begin
            bus.o_s_addr = bus.i_m1_addr;
            bus.o_s_we   = bus.i_m1_we;
            bus.o_s_dat  = bus.i_m1_dat;
        end
    end

    assign bus.o_s_cyc = owner_cyc_c & ~abort_c;
    assign bus.o_s_stb = ((grant0_c | grant1_c) && !abort_c) ? owner_stb_c : 4'b0000;
    assign bus.o_grant = {grant1_c, grant0_c};

    // Return path: only the granted, still-requesting master sees ack/err
    assign bus.o_m0_dat = bus.i_s_dat;
    assign bus.o_m1_dat = bus.i_s_dat;
    assign bus.o_m0_ack = bus.i_s_ack & grant0_c & bus.i_m0_cyc & ~abort_c;
    assign bus.o_m1_ack = bus.i_s_ack & grant1_c & bus.i_m1_cyc & ~abort_c;
    assign bus.o_m0_err = (bus.i_s_err | abort_c) & grant0_c & bus.i_m0_cyc;
    assign bus.o_m1_err = (bus.i_s_err | abort_c) & grant1_c & bus.i_m1_cyc;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Self-checking bench for wb_bus_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural model.
module tb_wb_bus_arbiter;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int TO_EN = 1;
    localparam int TB_TO = 4;
`else
    localparam int TO_EN = 0;
    localparam int TB_TO = 16;
`endif

    logic i_clk;
    logic i_reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    wb_bus_arbiter_if bus();

    wb_bus_arbiter #(.TIMEOUT(TB_TO)) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .bus     (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- behavioural reference model ----------------
    int m_owner = -1;   // -1: nobody owns the bus
    int m_last  = 1;
    int m_cnt   = 0;

    function automatic int next_owner(int own, int last, logic c0, logic c1);
        logic [1:0] c;
        c = {c1, c0};
        if (own >= 0 && c[own]) return own;
        if (own >= 0)           return c[1-own] ? 1 - own : -1;
        if (c0 && c1)           return 1 - last;
        if (c0)                 return 0;
        if (c1)                 return 1;
        return -1;
    endfunction

    function automatic int next_last(int own, int last, logic c0, logic c1);
        logic [1:0] c;
        c = {c1, c0};
        if (own >= 0 && !c[own]) return own;
        return last;
    endfunction

    function automatic int next_cnt(int own, int cnt, logic c0, logic c1,
                                    logic ack, logic err, logic abort, logic [3:0] stb);
        logic [1:0] c;
        c = {c1, c0};
        if (own < 0) return 0;
        if (!c[own] || ack || err || abort) return 0;
        if (stb != 4'b0000) return cnt + 1;
        return cnt;
    endfunction

    logic        e_abort, e_own_cyc, e_scyc, e_swe;
    logic [1:0]  e_grant;
    logic [3:0]  e_sstb, e_own_stb;
    logic [31:0] e_saddr, e_sdat;
    logic        e_m0_ack, e_m1_ack, e_m0_err, e_m1_err;

    always_comb begin
        e_grant   = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
        e_abort   = (TO_EN != 0) && (m_owner >= 0) && (m_cnt == TB_TO);
        e_own_cyc = (m_owner == 0) ? bus.i_m0_cyc : (m_owner == 1) ? bus.i_m1_cyc : 1'b0;
        e_own_stb = (m_owner == 1) ? bus.i_m1_stb : bus.i_m0_stb;
        e_scyc    = e_own_cyc && !e_abort;
        e_sstb    = (m_owner < 0 || e_abort) ? 4'b0000 : e_own_stb;
        e_saddr   = (m_owner == 1) ? bus.i_m1_addr : bus.i_m0_addr;
        e_swe     = (m_owner == 1) ? bus.i_m1_we   : bus.i_m0_we;
        e_sdat    = (m_owner == 1) ? bus.i_m1_dat  : bus.i_m0_dat;
        e_m0_ack  = bus.i_s_ack && m_owner == 0 && bus.i_m0_cyc && !e_abort;
        e_m1_ack  = bus.i_s_ack && m_owner == 1 && bus.i_m1_cyc && !e_abort;
        e_m0_err  = m_owner == 0 && bus.i_m0_cyc && (bus.i_s_err || e_abort);
        e_m1_err  = m_owner == 1 && bus.i_m1_cyc && (bus.i_s_err || e_abort);
    end

    always @(posedge i_clk) begin
        if (i_reset) begin
            m_owner <= -1;
            m_last  <= 1;
            m_cnt   <= 0;
        end else begin
            m_owner <= next_owner(m_owner, m_last, bus.i_m0_cyc, bus.i_m1_cyc);
            m_last  <= next_last(m_owner, m_last, bus.i_m0_cyc, bus.i_m1_cyc);
            m_cnt   <= next_cnt(m_owner, m_cnt, bus.i_m0_cyc, bus.i_m1_cyc,
                                bus.i_s_ack, bus.i_s_err, e_abort, e_own_stb);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic adv();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic c0, input logic c1, input logic ack, input logic err);
        bus.i_m0_cyc = c0;
        bus.i_m1_cyc = c1;
        bus.i_s_ack  = ack;
        bus.i_s_err  = err;
    endtask

    task automatic fixed_payload();
        bus.i_m0_addr = 32'h0000_0100;
        bus.i_m0_stb  = 4'b1100;
        bus.i_m0_we   = 1'b0;
        bus.i_m0_dat  = 32'h1111_1111;
        bus.i_m1_addr = 32'h0000_0200;
        bus.i_m1_stb  = 4'b1111;
        bus.i_m1_we   = 1'b1;
        bus.i_m1_dat  = 32'hDEAD_BEEF;
        bus.i_s_dat   = 32'hCAFE_0001;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        adv();
        i_reset = 1'b0;
    endtask

    typedef struct {
        logic        rst, c0, c1, ack, err;
        logic [1:0]  grant;
        logic        scyc;
        logic [3:0]  sstb;
        logic [31:0] saddr;
        logic        m0a, m1a, m0e, m1e;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int err_cnt;
        int cyc_lo;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 4'hC, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 4'hC, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 4'hC, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 4'hC, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 4'hF, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 4'hF, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 4'hC, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0};

        fixed_payload();
        do_reset();

        // Directed table
        for (int i = 0; i < 10; i++) begin
            i_reset = vecs[i].rst;
            drive(vecs[i].c0, vecs[i].c1, vecs[i].ack, vecs[i].err);
            @(negedge i_clk);
            check($sformatf("vec%0d", i),
                  128'({bus.o_grant, bus.o_s_cyc, bus.o_s_stb, bus.o_s_addr,
                        bus.o_m0_ack, bus.o_m1_ack, bus.o_m0_err, bus.o_m1_err}),
                  128'({vecs[i].grant, vecs[i].scyc, vecs[i].sstb, vecs[i].saddr,
                        vecs[i].m0a, vecs[i].m1a, vecs[i].m0e, vecs[i].m1e}));
            adv();
        end
        i_reset = 1'b0;

        // Strict alternation over 4 transfers after simultaneous requests
        do_reset();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge i_clk);
        check("alt_idle", 128'(bus.o_grant), 128'(2'b00));
        adv();
        for (int k = 0; k < 4; k++) begin
            logic [1:0] exp_g;
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge i_clk);
            check($sformatf("alt_grant%0d", k), 128'(bus.o_grant), 128'(exp_g));
            adv();
            bus.i_s_ack = 1'b1;
            @(negedge i_clk);
            check($sformatf("alt_ack%0d", k), 128'({bus.o_m1_ack, bus.o_m0_ack}), 128'(exp_g));
            adv();
            bus.i_s_ack = 1'b0;
            if (k % 2 == 0) bus.i_m0_cyc = 1'b0; else bus.i_m1_cyc = 1'b0;
            @(negedge i_clk);
            check($sformatf("alt_release%0d", k), 128'({bus.o_grant, bus.o_s_cyc}), 128'({exp_g, 1'b0}));
            adv();
            drive(1'b1, 1'b1, 1'b0, 1'b0);
        end

        // m1 holds a write while m0 waits
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        adv();
        bus.i_m0_cyc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            check($sformatf("hold%0d", k),
                  128'({bus.o_grant, bus.o_s_cyc, bus.o_s_we, bus.o_s_stb, bus.o_s_dat}),
                  128'({2'b10, 1'b1, 1'b1, 4'b1111, 32'hDEAD_BEEF}));
            adv();
        end
        bus.i_m1_cyc = 1'b0;
        @(negedge i_clk);
        check("hold_release", 128'({bus.o_grant, bus.o_s_cyc}), 128'({2'b10, 1'b0}));
        adv();
        @(negedge i_clk);
        check("hold_handover", 128'({bus.o_grant, bus.o_s_cyc, bus.o_s_addr}),
              128'({2'b01, 1'b1, 32'h100}));
        adv();

        // Reset while GRANT1 waits for ack
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        adv();
        adv();
        i_reset = 1'b1;
        adv();
        i_reset = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge i_clk);
        check("rst_mid", 128'({bus.o_grant, bus.o_s_cyc, bus.o_m0_ack, bus.o_m1_ack}),
              128'({2'b00, 1'b0, 1'b0, 1'b0}));
        adv();
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        adv();
        @(negedge i_clk);
        check("rst_first_grant", 128'(bus.o_grant), 128'(2'b01));
        adv();

        // Watchdog behaviour
        do_reset();
        bus.i_m0_stb = 4'b1111;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        adv();
`ifdef WB_ARB_TIMEOUT_EN
        for (int k = 0; k < TB_TO; k++) begin
            @(negedge i_clk);
            check($sformatf("to_wait%0d", k), 128'({bus.o_m0_err, bus.o_s_cyc}), 128'({1'b0, 1'b1}));
            adv();
        end
        @(negedge i_clk);
        check("to_abort", 128'({bus.o_m0_err, bus.o_m1_err, bus.o_s_cyc, bus.o_s_stb, bus.o_grant}),
              128'({1'b1, 1'b0, 1'b0, 4'b0000, 2'b01}));
        adv();
        @(negedge i_clk);
        check("to_after", 128'({bus.o_m0_err, bus.o_s_cyc, bus.o_grant}), 128'({1'b0, 1'b1, 2'b01}));
        adv();
`else
        err_cnt = 0;
        cyc_lo  = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge i_clk);
            if (bus.o_m0_err) err_cnt++;
            if (!bus.o_s_cyc) cyc_lo++;
            adv();
        end
        check("no_to_err", 128'(err_cnt), 128'(0));
        check("no_to_cyc", 128'(cyc_lo), 128'(0));
`endif
        fixed_payload();

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (bus.i_m0_cyc) bus.i_m0_cyc = ($urandom_range(3) != 0);
            else              bus.i_m0_cyc = ($urandom_range(1) != 0);
            if (bus.i_m1_cyc) bus.i_m1_cyc = ($urandom_range(3) != 0);
            else              bus.i_m1_cyc = ($urandom_range(1) != 0);
            bus.i_m0_addr = $urandom;
            bus.i_m1_addr = $urandom;
            bus.i_m0_dat  = $urandom;
            bus.i_m1_dat  = $urandom;
            bus.i_s_dat   = $urandom;
            bus.i_m0_stb  = 4'($urandom_range(15));
            bus.i_m1_stb  = 4'($urandom_range(15));
            bus.i_m0_we   = 1'($urandom_range(1));
            bus.i_m1_we   = 1'($urandom_range(1));
            bus.i_s_ack   = ($urandom_range(5) == 0);
            bus.i_s_err   = ($urandom_range(15) == 0);
            i_reset       = ($urandom_range(63) == 0);
            @(negedge i_clk);
            if (!i_reset) begin
                check($sformatf("rand_bus%0d", n),
                      128'({bus.o_grant, bus.o_s_cyc, bus.o_s_stb, bus.o_s_addr, bus.o_s_we, bus.o_s_dat}),
                      128'({e_grant, e_scyc, e_sstb, e_saddr, e_swe, e_sdat}));
                check($sformatf("rand_ret%0d", n),
                      128'({bus.o_m0_ack, bus.o_m0_err, bus.o_m1_ack, bus.o_m1_err, bus.o_m0_dat, bus.o_m1_dat}),
                      128'({e_m0_ack, e_m0_err, e_m1_ack, e_m1_err, bus.i_s_dat, bus.i_s_dat}));
            end
            adv();
        end
        i_reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
